// File: rtl/demux_16ch_tdm.sv
// -----------------------------------------------------------------------------
// demux_16ch_tdm
//
// Serial time-division demultiplexer. A frame is 16 single-bit slots arriving
// LSB (slot 0) first on din, qualified by din_valid. A sync strobe (only
// meaningful with din_valid) marks the current bit as slot 0 and aligns the
// receiver. Bits accumulate in a shadow register; when the final slot is
// accepted the completed frame is copied to out and out_valid pulses for one
// cycle. A partial frame never disturbs out.
//
// Optional feature (macro DEMUX_PARITY_CHECK_EN):
//   Adds a 17th slot (index 16) carrying even parity over slots 0-15. The
//   frame is published only if the parity holds; otherwise par_err pulses
//   and out keeps its previous value. Without the macro the frame is 16
//   slots, slot[4] is constant 0 and par_err is constant 0.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   din        in   1   serial data bit
//   din_valid  in   1   din carries a slot bit this cycle
//   sync       in   1   with din_valid: current bit is slot 0
//   out        out  16  last complete frame, bit i = slot i
//   out_valid  out  1   one-cycle pulse, out just updated
//   slot       out  5   slot index expected for the next valid bit
//   sync_err   out  1   one-cycle pulse, sync arrived mid-frame
//   par_err    out  1   one-cycle pulse, frame parity failure
// -----------------------------------------------------------------------------
module demux_16ch_tdm (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        din,
   input  logic        din_valid,
   input  logic        sync,
   output logic [15:0] out,
   output logic        out_valid,
   output logic [4:0]  slot,
   output logic        sync_err,
   output logic        par_err
);

`ifdef DEMUX_PARITY_CHECK_EN
   localparam int CW        = 5;
   localparam int FRAME_LEN = 17;
`else
   localparam int CW        = 4;
   localparam int FRAME_LEN = 16;
`endif

   localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_LEN - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t         state_q,     state_d;
   logic [CW-1:0]  slot_q,      slot_d;
   logic [15:0]    shadow_q,    shadow_d;
   logic [15:0]    out_q,       out_d;
   logic           out_valid_q, out_valid_d;
   logic           sync_err_q,  sync_err_d;
`ifdef DEMUX_PARITY_CHECK_EN
   logic           par_err_q,   par_err_d;
`endif

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         shadow_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
`ifdef DEMUX_PARITY_CHECK_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         shadow_q    <= shadow_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
`ifdef DEMUX_PARITY_CHECK_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   // --------------------------------------------------------------------------
   // Next-state / output logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      shadow_d    = shadow_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      sync_err_d  = 1'b0;
`ifdef DEMUX_PARITY_CHECK_EN
      par_err_d   = 1'b0;
`endif

      if (din_valid) begin
         if (sync) begin
            // Sync always realigns. Arriving anywhere but a frame boundary
            // means the partial frame is abandoned; the shadow is cleared so
            // no stale bits from it can leak into the next frame.
            sync_err_d  = (state_q == RUN) && (slot_q != '0);
            shadow_d    = '0;
            shadow_d[0] = din;
            slot_d      = CW'(1);
            state_d     = RUN;
         end else if (state_q == RUN) begin
`ifdef DEMUX_PARITY_CHECK_EN
            if (slot_q == LAST_SLOT) begin
               // Parity slot: even parity over data plus parity bit.
               if ((^shadow_q ^ din) == 1'b0) begin
                  out_d       = shadow_q;
                  out_valid_d = 1'b1;
               end else begin
                  par_err_d   = 1'b1;
               end
               slot_d = '0;
            end else begin
               shadow_d[slot_q[3:0]] = din;
               slot_d                = slot_q + CW'(1);
            end
`else
            shadow_d[slot_q[3:0]] = din;
            if (slot_q == LAST_SLOT) begin
               // shadow_d already contains the slot-15 bit.
               out_d       = shadow_d;
               out_valid_d = 1'b1;
               slot_d      = '0;
            end else begin
               slot_d      = slot_q + CW'(1);
            end
`endif
         end
         // IDLE without sync: bit is discarded, nothing changes.
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign sync_err  = sync_err_q;

`ifdef DEMUX_PARITY_CHECK_EN
   assign slot      = slot_q;
   assign par_err   = par_err_q;
`else
   assign slot      = {1'b0, slot_q};
   assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_demux_16ch_tdm.sv
module tb_demux_16ch_tdm;

`ifdef DEMUX_PARITY_CHECK_EN
   localparam int FL = 17;
`else
   localparam int FL = 16;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        din;
   logic        din_valid;
   logic        sync;
   logic [15:0] out;
   logic        out_valid;
   logic [4:0]  slot;
   logic        sync_err;
   logic        par_err;

   int n_checks = 0;
   int n_fail   = 0;

   // Results recorded by send_frame for the test tasks to compare.
   int ov_cnt;
   int ov_cyc;
   int err_cnt;

   demux_16ch_tdm dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .sync      (sync),
      .out       (out),
      .out_valid (out_valid),
      .slot      (slot),
      .sync_err  (sync_err),
      .par_err   (par_err)
   );

   always #5 clk = ~clk;

   // Present inputs for one clock; outputs are stable #1 after the edge.
   task automatic drive(input logic v, input logic s, input logic d);
      din_valid = v;
      sync      = s;
      din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic observe(input int cyc);
      if (out_valid) begin
         ov_cnt++;
         ov_cyc = cyc;
      end
      if (sync_err || par_err) err_cnt++;
   endtask

   // Sends one full frame (with a correct parity bit when enabled). A gap of
   // gap_len idle cycles (din_valid=0, sync=1 to confirm it is ignored) is
   // inserted after slot gap_at.
   task automatic send_frame(input logic [15:0] f, input logic with_sync,
                             input int gap_at, input int gap_len);
      int cyc;
      logic b;
      cyc     = 0;
      ov_cnt  = 0;
      ov_cyc  = -1;
      err_cnt = 0;
      for (int i = 0; i < FL; i++) begin
         b = (i < 16) ? f[i] : ^f;
         drive(1'b1, with_sync && (i == 0), b);
         cyc++;
         observe(cyc);
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               drive(1'b0, 1'b1, 1'b1);
               cyc++;
               observe(cyc);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (out !== 16'h0000) begin
         n_fail++; $display("FAIL reset_out: got %h expected 0000", out);
      end
      n_checks++;
      if (slot !== 5'd0) begin
         n_fail++; $display("FAIL reset_slot: got %0d expected 0", slot);
      end
      n_checks++;
      if ({out_valid, sync_err, par_err} !== 3'b000) begin
         n_fail++; $display("FAIL reset_pulses: got %b expected 000", {out_valid, sync_err, par_err});
      end
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_basic_frame();
      send_frame(16'hA5C3, 1'b1, -1, 0);
      n_checks++;
      if (ov_cnt !== 1 || ov_cyc !== FL) begin
         n_fail++; $display("FAIL basic_ov: got cnt %0d at %0d expected 1 at %0d", ov_cnt, ov_cyc, FL);
      end
      n_checks++;
      if (out !== 16'hA5C3) begin
         n_fail++; $display("FAIL basic_out: got %h expected a5c3", out);
      end
      n_checks++;
      if (slot !== 5'd0 || err_cnt !== 0) begin
         n_fail++; $display("FAIL basic_slot_err: got slot %0d errs %0d expected 0 0", slot, err_cnt);
      end
      drive(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || out !== 16'hA5C3) begin
         n_fail++; $display("FAIL basic_hold: got ov %b out %h expected 0 a5c3", out_valid, out);
      end
   endtask

   // Runs right after a completed frame, so the sync lands at slot 0 in RUN
   // and must not raise sync_err.
   task automatic test_gap();
      send_frame(16'hA5C3, 1'b1, 7, 3);
      n_checks++;
      if (ov_cnt !== 1 || ov_cyc !== FL + 3) begin
         n_fail++; $display("FAIL gap_ov: got cnt %0d at %0d expected 1 at %0d", ov_cnt, ov_cyc, FL + 3);
      end
      n_checks++;
      if (out !== 16'hA5C3 || err_cnt !== 0) begin
         n_fail++; $display("FAIL gap_out: got %h errs %0d expected a5c3 0", out, err_cnt);
      end
   endtask

   task automatic test_sync_err();
      logic [15:0] f;
      f = 16'h1234;
      for (int i = 0; i < 6; i++) drive(1'b1, (i == 0), 1'b1);
      n_checks++;
      if (slot !== 5'd6 || sync_err !== 1'b0) begin
         n_fail++; $display("FAIL serr_partial: got slot %0d serr %b expected 6 0", slot, sync_err);
      end
      drive(1'b1, 1'b1, f[0]);
      n_checks++;
      if (sync_err !== 1'b1 || slot !== 5'd1 || out !== 16'hA5C3) begin
         n_fail++; $display("FAIL serr_pulse: got serr %b slot %0d out %h expected 1 1 a5c3", sync_err, slot, out);
      end
      drive(1'b1, 1'b0, f[1]);
      n_checks++;
      if (sync_err !== 1'b0) begin
         n_fail++; $display("FAIL serr_one_cycle: got %b expected 0", sync_err);
      end
      for (int i = 2; i < 15; i++) drive(1'b1, 1'b0, f[i]);
      n_checks++;
      if (out !== 16'hA5C3 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL serr_retain: got out %h ov %b expected a5c3 0", out, out_valid);
      end
      drive(1'b1, 1'b0, f[15]);
`ifdef DEMUX_PARITY_CHECK_EN
      drive(1'b1, 1'b0, ^f);
`endif
      n_checks++;
      if (out !== 16'h1234 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL serr_new_frame: got out %h ov %b expected 1234 1", out, out_valid);
      end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 5; i++) drive(1'b1, (i == 0), 1'b1);
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      n_checks++;
      if (out !== 16'h0000 || slot !== 5'd0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid: got out %h slot %0d ov %b expected 0000 0 0", out, slot, out_valid);
      end
   endtask

   task automatic test_no_sync();
      int ov;
      ov = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b0, 1'b1);
         if (out_valid) ov++;
      end
      n_checks++;
      if (out !== 16'h0000 || slot !== 5'd0 || ov !== 0) begin
         n_fail++; $display("FAIL no_sync: got out %h slot %0d ov %0d expected 0000 0 0", out, slot, ov);
      end
   endtask

   task automatic test_back_to_back();
      send_frame(16'hFFFF, 1'b1, -1, 0);
      n_checks++;
      if (ov_cnt !== 1 || out !== 16'hFFFF) begin
         n_fail++; $display("FAIL b2b_first: got cnt %0d out %h expected 1 ffff", ov_cnt, out);
      end
      send_frame(16'h0001, 1'b0, -1, 0);
      n_checks++;
      if (ov_cnt !== 1 || ov_cyc !== FL || out !== 16'h0001) begin
         n_fail++; $display("FAIL b2b_second: got cnt %0d at %0d out %h expected 1 at %0d 0001", ov_cnt, ov_cyc, out, FL);
      end
      n_checks++;
      if (err_cnt !== 0 || slot !== 5'd0) begin
         n_fail++; $display("FAIL b2b_err_slot: got errs %0d slot %0d expected 0 0", err_cnt, slot);
      end
   endtask

`ifdef DEMUX_PARITY_CHECK_EN
   task automatic test_parity();
      logic [15:0] f;
      logic [15:0] prev;
      f    = 16'h0007;
      prev = out;
      for (int i = 0; i < 16; i++) drive(1'b1, (i == 0), f[i]);
      n_checks++;
      if (slot !== 5'd16) begin
         n_fail++; $display("FAIL par_slot16: got %0d expected 16", slot);
      end
      drive(1'b1, 1'b0, 1'b0);
      n_checks++;
      if (par_err !== 1'b1 || out_valid !== 1'b0 || out !== prev || slot !== 5'd0) begin
         n_fail++; $display("FAIL par_bad: got perr %b ov %b out %h slot %0d expected 1 0 %h 0", par_err, out_valid, out, slot, prev);
      end
      for (int i = 0; i < 16; i++) drive(1'b1, (i == 0), f[i]);
      drive(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (par_err !== 1'b0 || out_valid !== 1'b1 || out !== 16'h0007) begin
         n_fail++; $display("FAIL par_good: got perr %b ov %b out %h expected 0 1 0007", par_err, out_valid, out);
      end
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      din       = 1'b0;
      din_valid = 1'b0;
      sync      = 1'b0;
      #2;
      test_reset();
      test_basic_frame();
      test_gap();
      test_sync_err();
      test_reset_midframe();
      test_no_sync();
      do_reset();
      test_back_to_back();
`ifdef DEMUX_PARITY_CHECK_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
